uart_tx_arbiter: RTL

//  Round-robin arbiter sharing the single UART TX FIFO write port among NUM_REQ byte-stream

---
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among NUM_REQ byte streams.
// A grant covers a whole packet, bounded by a burst limit and an idle timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 255,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         fifo_din,
  output logic                      fifo_wr_en,
  input  logic                      fifo_full,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam int BURST_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam int IDLE_W  = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [BURST_W-1:0] burst_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [ID_W-1:0]    next_id;
  logic               g_valid;
  logic               g_last;
  logic               xfer;
  logic               release_now;

  // Handshake: a byte moves on requester i in a cycle where req_valid[i] & req_ready[i];
  // the same cycle raises fifo_wr_en. req_ready only depends on grant and fifo_full.
  assign busy    = (state == GRANT);
  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign xfer    = busy && g_valid && !fifo_full;

  assign fifo_wr_en = xfer;
  assign fifo_din   = busy ? req_data[int'(grant_id)*DATA_W +: DATA_W] : '0;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy && (int'(grant_id) == i) && !fifo_full;
    end
  end

  always_comb begin
    release_now = 1'b0;
    if (xfer && g_last) release_now = 1'b1;
    if (xfer && (MAX_BURST != 0) && (burst_cnt == BURST_LAST)) release_now = 1'b1;
    if (busy && (IDLE_TIMEOUT != 0) && !g_valid && (idle_cnt == IDLE_LAST)) release_now = 1'b1;
  end

  // First valid requester searching upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    next_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        next_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id  <= next_id;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) burst_cnt <= burst_cnt + BURST_W'(1);
          // A fifo_full stall with data present is not idle time.
          if (g_valid) idle_cnt <= '0;
          else         idle_cnt <= idle_cnt + IDLE_W'(1);
          if (release_now) begin
            state  <= IDLE;
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
